coreahblite_masterstage: RTL and testbench
==========================================

# coreahblite_masterstage

Per-master data-phase stage of the AHB-Lite matrix, directly downstream of the address decoder. Takes the decoder's 17-bit slave-select vector and no-decode flag for the current address phase, gates them into per-slave HSEL, registers the selection into the data phase, and returns that slave's HREADYOUT/HRESP/HRDATA to the master. Unmapped and disabled regions are served by an integrated default slave with the two-cycle AHB ERROR response.

## Interface
- SLAVE_EN, 17'h1FFFF, bit n enables slot n (bits 15:0 = 16 regular slots, bit 16 = upper-half/remapped slot); a select to a disabled slot is treated as no-decode.
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETN  in  1  asynchronous active-low reset.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- SSEL  in  17  one-hot (or zero) slave select from the address decoder, address phase.
- NODEC  in  1  decoder no-slave flag, address phase.
- HSEL_S  out  17  per-slave HSEL = SSEL & SLAVE_EN (combinational).
- HREADYOUT_S  in  17  per-slave HREADYOUT.
- HRESP_S  in  17  per-slave HRESP.
- HRDATA_S  in  544  slave read data, slot n at [32n+31:32n].
- HREADY_M  out  1  HREADY to master and to all slaves' HREADY input.
- HRESP_M  out  1  response to master (0 OKAY, 1 ERROR).
- HRDATA_M  out  32  read data to master.
- DSEL  out  17  registered data-phase select (for debug / arbiter use).

## Operation
- Address-phase decode: sel_ok = SSEL & SLAVE_EN; bad = NODEC | (SSEL != 0 & sel_ok == 0).
- Data-phase register DSEL: loaded only when HREADY_M = 1; DSEL <= sel_ok. Holds while HREADY_M = 0.
- Default-slave FSM states IDLE, ERR1, ERR2:
  - IDLE: if HREADY_M = 1 and bad and HTRANS[1] = 1 -> ERR1. Otherwise stay.
  - ERR1: HREADY_M = 0, HRESP_M = 1, HRDATA_M = 0; unconditionally -> ERR2.
  - ERR2: HREADY_M = 1, HRESP_M = 1, HRDATA_M = 0; address phase sampled this cycle as normal: if bad and HTRANS[1] -> ERR1, else -> IDLE.
- bad with HTRANS IDLE/BUSY: no FSM transition, DSEL loads zero, data phase is zero-wait OKAY.
- Return mux (FSM in IDLE): DSEL one-hot slot n -> HREADY_M = HREADYOUT_S[n], HRESP_M = HRESP_S[n], HRDATA_M = slot n data. DSEL = 0 -> HREADY_M = 1, HRESP_M = 0, HRDATA_M = 0.
- DSEL multi-hot (decoder fault): lowest set bit wins.
- Slave ERROR responses pass through unmodified; the stage does not re-time them.

## Timing
- Reset (HRESETN low, asynchronous): FSM = IDLE, DSEL = 0; hence HREADY_M = 1, HRESP_M = 0, HRDATA_M = 0, HSEL_S follows SSEL immediately.
- Reset asserted mid-transfer (wait state or ERR1) aborts it; first cycle after deassertion is zero-wait OKAY.
- HSEL_S: zero latency. HREADY_M/HRESP_M/HRDATA_M: combinational from registered state and slave inputs, zero added latency in the data phase.
- Address phase accepted at edge k (HREADY_M = 1) -> DSEL valid from k, response visible in cycle k+1.
- Error to unmapped address: cycle k+1 HREADY=0/HRESP=1, cycle k+2 HREADY=1/HRESP=1; exactly 2 cycles, never extended.
- Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2... no IDLE cycle between.
- Slave wait states: arbitrary length; DSEL and FSM frozen while HREADY_M = 0.

## Test plan
- Reset: HRESETN low for 3 cycles with SSEL = 17'h00004, HTRANS = NONSEQ -> HREADY_M = 1, HRESP_M = 0, HRDATA_M = 0, DSEL = 0, HSEL_S = 17'h00004.
- Read slot 2: SSEL = 17'h00004, NONSEQ; slot 2 holds HREADYOUT low 2 cycles, data 32'hCAFE0002 -> HREADY_M low 2 cycles then high with HRDATA_M = 32'hCAFE0002, DSEL = 17'h00004 throughout.
- Unmapped: NODEC = 1, NONSEQ -> next cycle HREADY_M = 0/HRESP_M = 1, following cycle HREADY_M = 1/HRESP_M = 1, then OKAY.
- Disabled slot: SLAVE_EN = 17'h0FFFF, SSEL = 17'h10000, SEQ -> HSEL_S = 0, two-cycle ERROR; same with HTRANS = IDLE -> zero-wait OKAY, no ERROR.
- Back-to-back: two consecutive unmapped NONSEQ followed by slot 0 read of 32'h12345678 -> ERR1, ERR2, ERR1, ERR2, then HRDATA_M = 32'h12345678 with HRESP_M = 0.
- Reset during ERR1: HRESETN pulsed low in ERR1 cycle -> HREADY_M = 1, HRESP_M = 0 immediately; no ERR2 after release.

Source files
------------

// File: rtl/coreahblite_masterstage_if.sv
// Bus bundle between one AHB-Lite master, its address decoder and the slave
// slots, as seen by the per-master data-phase stage.
interface coreahblite_masterstage_if;
  logic [1:0]   HTRANS;
  logic [16:0]  SSEL;
  logic         NODEC;
  logic [16:0]  HSEL_S;
  logic [16:0]  HREADYOUT_S;
  logic [16:0]  HRESP_S;
  logic [543:0] HRDATA_S;
  logic         HREADY_M;
  logic         HRESP_M;
  logic [31:0]  HRDATA_M;
  logic [16:0]  DSEL;

  // Stage side: takes decode and slave returns, drives HSEL and master returns.
  modport slave (
    input  HTRANS, SSEL, NODEC, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HSEL_S, HREADY_M, HRESP_M, HRDATA_M, DSEL
  );

  // Environment side: master, decoder and slaves together.
  modport master (
    output HTRANS, SSEL, NODEC, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HSEL_S, HREADY_M, HRESP_M, HRDATA_M, DSEL
  );
endinterface

// File: rtl/coreahblite_masterstage.sv
// Per-master data-phase stage: gates the decoder select into HSEL, registers
// it into the data phase and muxes the selected slave's response back to the
// master. Unmapped or disabled targets get a two-cycle ERROR from a built-in
// default slave.
//
// state | meaning
// IDLE  | no default-slave response; return path follows DSEL
// ERR1  | first ERROR cycle, HREADY low
// ERR2  | second ERROR cycle, HREADY high, next address phase sampled
module coreahblite_masterstage #(
  parameter logic [16:0] SLAVE_EN = 17'h1FFFF
) (
  input logic HCLK,
  input logic HRESETN,
  coreahblite_masterstage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [16:0] sel_ok;
  logic        bad;
  logic        err_req;
  logic [16:0] dsel;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  // A select that lands only on disabled slots is treated like no-decode.
  always_comb begin
    sel_ok  = bus.SSEL & SLAVE_EN;
    bad     = bus.NODEC | ((bus.SSEL != 17'd0) && (sel_ok == 17'd0));
    err_req = bad & bus.HTRANS[1];
  end

  assign bus.HSEL_S   = sel_ok;
  assign bus.DSEL     = dsel;
  assign bus.HREADY_M = hready;
  assign bus.HRESP_M  = hresp;
  assign bus.HRDATA_M = hrdata;

  // Data-phase select advances only when the current transfer completes.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      dsel <= 17'd0;
    end else if (hready) begin
      dsel <= sel_ok;
    end
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and return mux; lowest set DSEL bit wins on a multi-hot fault.
  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'd0;
    case (state)
      ST_IDLE: begin
        for (int n = 16; n >= 0; n--) begin
          if (dsel[n]) begin
            hready = bus.HREADYOUT_S[n];
            hresp  = bus.HRESP_S[n];
            hrdata = bus.HRDATA_S[32*n +: 32];
          end
        end
        if (hready && err_req) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hready    = 1'b1;
        hresp     = 1'b1;
        state_nxt = err_req ? ST_ERR1 : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coreahblite_masterstage.sv
// Directed bench for coreahblite_masterstage. Two instances share one stimulus:
// u_all has every slot enabled, u_dis has slot 16 disabled.
module tb_coreahblite_masterstage;
  logic         HCLK;
  logic         HRESETN;
  logic [1:0]   htrans;
  logic [16:0]  ssel;
  logic         nodec;
  logic [16:0]  hreadyout_s;
  logic [16:0]  hresp_s;
  logic [543:0] hrdata_s;

  int checks = 0;
  int failures = 0;

  coreahblite_masterstage_if bus_all ();
  coreahblite_masterstage_if bus_dis ();

  assign bus_all.HTRANS      = htrans;
  assign bus_all.SSEL        = ssel;
  assign bus_all.NODEC       = nodec;
  assign bus_all.HREADYOUT_S = hreadyout_s;
  assign bus_all.HRESP_S     = hresp_s;
  assign bus_all.HRDATA_S    = hrdata_s;
  assign bus_dis.HTRANS      = htrans;
  assign bus_dis.SSEL        = ssel;
  assign bus_dis.NODEC       = nodec;
  assign bus_dis.HREADYOUT_S = hreadyout_s;
  assign bus_dis.HRESP_S     = hresp_s;
  assign bus_dis.HRDATA_S    = hrdata_s;

  coreahblite_masterstage #(.SLAVE_EN(17'h1FFFF)) u_all (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus_all)
  );
  coreahblite_masterstage #(.SLAVE_EN(17'h0FFFF)) u_dis (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus_dis)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #3;
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
    chk({tag, "_ready"}, 64'(bus_all.HREADY_M), 64'(rdy));
    chk({tag, "_resp"},  64'(bus_all.HRESP_M),  64'(rsp));
    chk({tag, "_data"},  64'(bus_all.HRDATA_M), 64'(dat));
  endtask

  initial begin
    HRESETN     = 1'b0;
    htrans      = 2'b10;
    ssel        = 17'h00004;
    nodec       = 1'b0;
    hreadyout_s = '1;
    hresp_s     = '0;
    for (int n = 0; n < 17; n++) hrdata_s[32*n +: 32] = {16'hCAFE, 16'(n)};
    hrdata_s[31:0] = 32'h12345678;

    // Reset held for three cycles with a NONSEQ to slot 2 on the bus.
    repeat (3) cyc();
    settle();
    chk_resp("rst", 1'b1, 1'b0, 32'h0);
    chk("rst_dsel", 64'(bus_all.DSEL), 64'h0);
    chk("rst_hsel", 64'(bus_all.HSEL_S), 64'h00004);

    // Read slot 2 with two wait states.
    HRESETN = 1'b1;
    cyc();
    htrans = 2'b00; ssel = 17'h0; hreadyout_s[2] = 1'b0;
    settle();
    chk("rd2_w1_ready", 64'(bus_all.HREADY_M), 64'h0);
    chk("rd2_w1_dsel", 64'(bus_all.DSEL), 64'h00004);
    cyc();
    settle();
    chk("rd2_w2_ready", 64'(bus_all.HREADY_M), 64'h0);
    chk("rd2_w2_dsel", 64'(bus_all.DSEL), 64'h00004);
    cyc();
    hreadyout_s[2] = 1'b1;
    settle();
    chk_resp("rd2_done", 1'b1, 1'b0, 32'hCAFE0002);
    chk("rd2_done_dsel", 64'(bus_all.DSEL), 64'h00004);

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY.
    cyc();
    nodec = 1'b1; htrans = 2'b10;
    settle();
    chk_resp("unm_addr", 1'b1, 1'b0, 32'h0);
    cyc();
    nodec = 1'b0; htrans = 2'b00;
    settle();
    chk_resp("unm_err1", 1'b0, 1'b1, 32'h0);
    cyc();
    settle();
    chk_resp("unm_err2", 1'b1, 1'b1, 32'h0);
    cyc();
    settle();
    chk_resp("unm_after", 1'b1, 1'b0, 32'h0);

    // Disabled slot 16 with SEQ.
    cyc();
    ssel = 17'h10000; htrans = 2'b11;
    settle();
    chk("dis_hsel", 64'(bus_dis.HSEL_S), 64'h0);
    chk("en_hsel", 64'(bus_all.HSEL_S), 64'h10000);
    cyc();
    ssel = 17'h0; htrans = 2'b00;
    settle();
    chk("dis_err1_ready", 64'(bus_dis.HREADY_M), 64'h0);
    chk("dis_err1_resp", 64'(bus_dis.HRESP_M), 64'h1);
    chk("en_slot16_data", 64'(bus_all.HRDATA_M), 64'hCAFE0010);
    cyc();
    settle();
    chk("dis_err2_ready", 64'(bus_dis.HREADY_M), 64'h1);
    chk("dis_err2_resp", 64'(bus_dis.HRESP_M), 64'h1);
    // Same disabled target but HTRANS IDLE: no error.
    cyc();
    ssel = 17'h10000; htrans = 2'b00;
    settle();
    chk("dis_idle_addr_resp", 64'(bus_dis.HRESP_M), 64'h0);
    cyc();
    ssel = 17'h0;
    settle();
    chk("dis_idle_ready", 64'(bus_dis.HREADY_M), 64'h1);
    chk("dis_idle_resp", 64'(bus_dis.HRESP_M), 64'h0);
    chk("dis_idle_dsel", 64'(bus_dis.DSEL), 64'h0);

    // Back-to-back unmapped NONSEQ, then slot 0 read.
    cyc();
    nodec = 1'b1; htrans = 2'b10;
    settle();
    chk_resp("b2b_addr", 1'b1, 1'b0, 32'h0);
    cyc();
    settle();
    chk_resp("b2b_err1a", 1'b0, 1'b1, 32'h0);
    cyc();
    settle();
    chk_resp("b2b_err2a", 1'b1, 1'b1, 32'h0);
    cyc();
    nodec = 1'b0; ssel = 17'h00001;
    settle();
    chk_resp("b2b_err1b", 1'b0, 1'b1, 32'h0);
    cyc();
    settle();
    chk_resp("b2b_err2b", 1'b1, 1'b1, 32'h0);
    cyc();
    ssel = 17'h0; htrans = 2'b00;
    settle();
    chk_resp("b2b_rd0", 1'b1, 1'b0, 32'h12345678);
    chk("b2b_rd0_dsel", 64'(bus_all.DSEL), 64'h00001);

    // Multi-hot data-phase select: lowest slot wins.
    cyc();
    ssel = 17'h00006; htrans = 2'b10;
    cyc();
    ssel = 17'h0; htrans = 2'b00;
    settle();
    chk("multi_data", 64'(bus_all.HRDATA_M), 64'hCAFE0001);

    // Reset pulsed during ERR1 aborts the error.
    cyc();
    nodec = 1'b1; htrans = 2'b10;
    cyc();
    nodec = 1'b0; htrans = 2'b00;
    settle();
    chk("rerr_err1_ready", 64'(bus_all.HREADY_M), 64'h0);
    HRESETN = 1'b0;
    #1;
    chk_resp("rerr_inrst", 1'b1, 1'b0, 32'h0);
    cyc();
    HRESETN = 1'b1;
    settle();
    chk_resp("rerr_rel", 1'b1, 1'b0, 32'h0);
    cyc();
    settle();
    chk_resp("rerr_noerr2", 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
